// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for CPU_Datapath: steps T0-T6 per instruction and
// decodes the IR into one-hot register enables, ALU select and datapath strobes.
module control_sequencer #(
   parameter int unsigned NREG         = 16,
   parameter int unsigned DIV_WAIT_MAX = 40
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            run,
   input  logic [31:0]     ir,
   input  logic            mem_rdy,
   input  logic            alu_done,
   output logic [NREG-1:0] reg_in,
   output logic [NREG-1:0] reg_out,
   output logic            pc_out,
   output logic            mar_in,
   output logic            inc_pc,
   output logic            pc_in,
   output logic            read,
   output logic            mdr_in,
   output logic            mdr_out,
   output logic            ir_in,
   output logic            y_in,
   output logic            z_in,
   output logic            zlo_out,
   output logic            zhi_out,
   output logic            lo_in,
   output logic            hi_in,
   output logic [4:0]      alu_sel,
   output logic            illegal,
   output logic            halted
);

   localparam int unsigned CW = (DIV_WAIT_MAX > 1) ? $clog2(DIV_WAIT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_WAIT_MAX - 1);

   // T1W is the mem_rdy wait after the first T1 cycle, so pc_in pulses only once
   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DABT, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_BIN, C_UN, C_MUL, C_DIV, C_NOP, C_HALT, C_ILL
   } cls_t;

   state_t        state_q, state_d;
   cls_t          cls_q;
   cls_t          cls_ir;
   logic [4:0]    op_q;
   logic [3:0]    ra_q, rb_q, rc_q;
   logic [CW-1:0] div_cnt;
   state_t        end_state;
   logic          unused_ir;

   function automatic cls_t classify(input logic [4:0] op);
      cls_t c;
      if (op <= 5'd10)                    c = C_BIN;
      else if (op == 5'd14)               c = C_MUL;
      else if (op == 5'd15)               c = C_DIV;
      else if (op == 5'd16 || op == 5'd17) c = C_UN;
      else if (op == 5'd26)               c = C_NOP;
      else if (op == 5'd27)               c = C_HALT;
      else                                c = C_ILL;
      return c;
   endfunction

   function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
      return NREG'(1) << idx;
   endfunction

   assign cls_ir    = classify(ir[31:27]);
   assign end_state = run ? S_T0 : S_IDLE;
   assign unused_ir = &{1'b0, ir[14:0]};

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // IR is only valid once T3 is entered, so fields are captured at the end of T3
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cls_q <= C_NOP;
         op_q  <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
         rc_q  <= '0;
      end else if (state_q == S_T3) begin
         cls_q <= cls_ir;
         op_q  <= ir[31:27];
         ra_q  <= ir[26:23];
         rb_q  <= ir[22:19];
         rc_q  <= ir[18:15];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div_cnt <= '0;
      end else if (state_q == S_T4 && cls_q == C_DIV) begin
         if (div_cnt != CNT_LAST) div_cnt <= div_cnt + CW'(1);
      end else begin
         div_cnt <= '0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1,
         S_T1W:  state_d = mem_rdy ? S_T2 : S_T1W;
         S_T2:   state_d = S_T3;
         S_T3: begin
            unique case (cls_ir)
               C_BIN, C_UN, C_MUL, C_DIV: state_d = S_T4;
               C_HALT:                    state_d = S_HALT;
               default:                   state_d = end_state;
            endcase
         end
         S_T4: begin
            unique case (cls_q)
               C_BIN, C_MUL: state_d = S_T5;
               C_DIV: begin
                  if (alu_done)                 state_d = S_T5;
                  else if (div_cnt == CNT_LAST) state_d = S_DABT;
                  else                          state_d = S_T4;
               end
               default: state_d = end_state;
            endcase
         end
         S_T5: begin
            if (cls_q == C_MUL || cls_q == C_DIV) state_d = S_T6;
            else                                  state_d = end_state;
         end
         S_T6,
         S_DABT: state_d = end_state;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reg_in  = '0;
      reg_out = '0;
      alu_sel = '0;
      pc_out  = 1'b0;
      mar_in  = 1'b0;
      inc_pc  = 1'b0;
      pc_in   = 1'b0;
      read    = 1'b0;
      mdr_in  = 1'b0;
      mdr_out = 1'b0;
      ir_in   = 1'b0;
      y_in    = 1'b0;
      z_in    = 1'b0;
      zlo_out = 1'b0;
      zhi_out = 1'b0;
      lo_in   = 1'b0;
      hi_in   = 1'b0;
      illegal = 1'b0;
      halted  = 1'b0;
      unique case (state_q)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         S_T1: begin
            zlo_out = 1'b1;
            pc_in   = 1'b1;
            read    = 1'b1;
            mdr_in  = 1'b1;
         end
         S_T1W: begin
            zlo_out = 1'b1;
            read    = 1'b1;
            mdr_in  = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: begin
            unique case (cls_ir)
               C_BIN: begin
                  reg_out = onehot(ir[22:19]);
                  y_in    = 1'b1;
               end
               C_UN: begin
                  reg_out = onehot(ir[22:19]);
                  alu_sel = ir[31:27];
                  z_in    = 1'b1;
               end
               C_MUL, C_DIV: begin
                  reg_out = onehot(ir[26:23]);
                  y_in    = 1'b1;
               end
               C_ILL:   illegal = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            unique case (cls_q)
               C_BIN: begin
                  reg_out = onehot(rc_q);
                  alu_sel = op_q;
                  z_in    = 1'b1;
               end
               C_UN: begin
                  zlo_out = 1'b1;
                  reg_in  = onehot(ra_q);
               end
               C_MUL, C_DIV: begin
                  reg_out = onehot(rb_q);
                  alu_sel = op_q;
                  z_in    = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            unique case (cls_q)
               C_BIN: begin
                  zlo_out = 1'b1;
                  reg_in  = onehot(ra_q);
               end
               C_MUL, C_DIV: begin
                  zlo_out = 1'b1;
                  lo_in   = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            zhi_out = 1'b1;
            hi_in   = 1'b1;
         end
         S_DABT:  illegal = 1'b1;
         S_HALT:  halted  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected control words queued as each instruction
// is launched, then popped and compared one per clock.
module tb_control_sequencer;

   localparam logic [15:0] F_PC_OUT  = 16'h8000;
   localparam logic [15:0] F_MAR_IN  = 16'h4000;
   localparam logic [15:0] F_INC_PC  = 16'h2000;
   localparam logic [15:0] F_PC_IN   = 16'h1000;
   localparam logic [15:0] F_READ    = 16'h0800;
   localparam logic [15:0] F_MDR_IN  = 16'h0400;
   localparam logic [15:0] F_MDR_OUT = 16'h0200;
   localparam logic [15:0] F_IR_IN   = 16'h0100;
   localparam logic [15:0] F_Y_IN    = 16'h0080;
   localparam logic [15:0] F_Z_IN    = 16'h0040;
   localparam logic [15:0] F_ZLO     = 16'h0020;
   localparam logic [15:0] F_ZHI     = 16'h0010;
   localparam logic [15:0] F_LO_IN   = 16'h0008;
   localparam logic [15:0] F_HI_IN   = 16'h0004;
   localparam logic [15:0] F_ILL     = 16'h0002;
   localparam logic [15:0] F_HALT    = 16'h0001;
   localparam int NV = 12;

   logic        clk = 1'b0;
   logic        clr, run, mem_rdy, alu_done;
   logic [31:0] ir;
   logic [15:0] reg_in, reg_out;
   logic [4:0]  alu_sel;
   logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
   logic y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, illegal, halted;

   typedef struct {
      logic [31:0]      ir;
      int               waits;
      logic             ad;
      int               n;
      logic [3:0][52:0] ex;
   } vec_t;

   vec_t        tbl [NV];
   logic [52:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   control_sequencer #(.NREG(16), .DIV_WAIT_MAX(40)) dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy), .alu_done(alu_done),
      .reg_in(reg_in), .reg_out(reg_out), .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc),
      .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
      .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in),
      .hi_in(hi_in), .alu_sel(alu_sel), .illegal(illegal), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [52:0] mk(input logic [15:0] ri, input logic [15:0] ro,
                                      input logic [4:0] sel, input logic [15:0] f);
      return {ri, ro, sel, f};
   endfunction

   function automatic logic [52:0] actual();
      return {reg_in, reg_out, alu_sel, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out,
              ir_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, illegal, halted};
   endfunction

   task automatic check(input string name, input logic [52:0] exp);
      logic [52:0] act;
      act = actual();
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got ri=%h ro=%h sel=%h f=%h, expected ri=%h ro=%h sel=%h f=%h",
                    name, $time, act[52:37], act[36:21], act[20:16], act[15:0],
                    exp[52:37], exp[36:21], exp[20:16], exp[15:0]);
   endtask

   task automatic push_fetch(input int waits);
      exp_q.push_back(mk('0, '0, '0, F_PC_OUT | F_MAR_IN | F_INC_PC | F_Z_IN));
      exp_q.push_back(mk('0, '0, '0, F_ZLO | F_PC_IN | F_READ | F_MDR_IN));
      for (int w = 0; w < waits; w++) exp_q.push_back(mk('0, '0, '0, F_ZLO | F_READ | F_MDR_IN));
      exp_q.push_back(mk('0, '0, '0, F_MDR_OUT | F_IR_IN));
   endtask

   // DUT must be idle on entry; one expected word is consumed per clock
   task automatic run_queue(input string name, input int waits, input int run_drop_c,
                            input int scramble_c);
      int c;
      c       = 0;
      run     = 1'b1;
      mem_rdy = 1'b0;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         c++;
         check($sformatf("%s.c%0d", name, c), exp_q.pop_front());
         if (c == run_drop_c) run = 1'b0;
         mem_rdy = (c + 1 > 2 + waits);
         if (c == scramble_c) ir = 32'hFFFF_FFFF;
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] v_ir, input int waits, input logic ad,
                          input int n, input logic [52:0] e0, input logic [52:0] e1,
                          input logic [52:0] e2, input logic [52:0] e3);
      tbl[i].ir    = v_ir;
      tbl[i].waits = waits;
      tbl[i].ad    = ad;
      tbl[i].n     = n;
      tbl[i].ex    = {e3, e2, e1, e0};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [52:0] z;
      z = '0;
      // and R1,R2,R3 with and without memory wait
      set_vec(0, 32'h28918000, 0, 1'b0, 3, mk('0, 16'h0004, '0, F_Y_IN),
              mk('0, 16'h0008, 5'h05, F_Z_IN), mk(16'h0002, '0, '0, F_ZLO), z);
      set_vec(1, 32'h28918000, 3, 1'b0, 3, mk('0, 16'h0004, '0, F_Y_IN),
              mk('0, 16'h0008, 5'h05, F_Z_IN), mk(16'h0002, '0, '0, F_ZLO), z);
      set_vec(2, 32'h70900000, 0, 1'b0, 4, mk('0, 16'h0002, '0, F_Y_IN),
              mk('0, 16'h0004, 5'h0E, F_Z_IN), mk('0, '0, '0, F_ZLO | F_LO_IN),
              mk('0, '0, '0, F_ZHI | F_HI_IN));
      set_vec(3, 32'h78900000, 0, 1'b1, 4, mk('0, 16'h0002, '0, F_Y_IN),
              mk('0, 16'h0004, 5'h0F, F_Z_IN), mk('0, '0, '0, F_ZLO | F_LO_IN),
              mk('0, '0, '0, F_ZHI | F_HI_IN));
      set_vec(4, 32'h80780000, 0, 1'b0, 2, mk('0, 16'h8000, 5'h10, F_Z_IN),
              mk(16'h0001, '0, '0, F_ZLO), z, z);
      set_vec(5, 32'h8AA80000, 1, 1'b0, 2, mk('0, 16'h0020, 5'h11, F_Z_IN),
              mk(16'h0020, '0, '0, F_ZLO), z, z);
      set_vec(6, 32'h03BB8000, 0, 1'b0, 3, mk('0, 16'h0080, '0, F_Y_IN),
              mk('0, 16'h0080, 5'h00, F_Z_IN), mk(16'h0080, '0, '0, F_ZLO), z);
      set_vec(7, 32'h57808000, 0, 1'b0, 3, mk('0, 16'h0001, '0, F_Y_IN),
              mk('0, 16'h0002, 5'h0A, F_Z_IN), mk(16'h8000, '0, '0, F_ZLO), z);
      set_vec(8, 32'h58000000, 0, 1'b0, 1, mk('0, '0, '0, F_ILL), z, z, z);
      set_vec(9, 32'hD0000000, 0, 1'b0, 1, z, z, z, z);
      set_vec(10, 32'hF8000000, 0, 1'b0, 1, mk('0, '0, '0, F_ILL), z, z, z);
      set_vec(11, 32'h90000000, 2, 1'b0, 1, mk('0, '0, '0, F_ILL), z, z, z);

      clr      = 1'b1;
      run      = 1'b1;
      ir       = 32'hD0000000;
      mem_rdy  = 1'b1;
      alu_done = 1'b0;
      #5 clr = 1'b0;
      #1 check("reset", z);
      @(negedge clk);
      clr = 1'b1;
      push_fetch(0);
      exp_q.push_back(z);
      exp_q.push_back(z);
      run_queue("after_reset", 0, 1, -1);

      for (int i = 0; i < NV; i++) begin
         ir       = tbl[i].ir;
         alu_done = tbl[i].ad;
         push_fetch(tbl[i].waits);
         for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].ex[k]);
         exp_q.push_back(z);
         run_queue($sformatf("vec%0d", i), tbl[i].waits, 1, -1);
      end
      alu_done = 1'b0;

      // nop then illegal with run held: second T0 immediately follows the nop's T3
      ir = 32'hD0000000;
      push_fetch(0);
      exp_q.push_back(z);
      push_fetch(0);
      exp_q.push_back(mk('0, '0, '0, F_ILL));
      exp_q.push_back(z);
      fork
         begin
            @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk);
            #2 ir = 32'h58000000;
         end
      join_none
      run_queue("b2b", 0, 5, -1);

      // and: ir corrupted after T4, result must still land in R1
      ir = 32'h28918000;
      push_fetch(0);
      exp_q.push_back(mk('0, 16'h0004, '0, F_Y_IN));
      exp_q.push_back(mk('0, 16'h0008, 5'h05, F_Z_IN));
      exp_q.push_back(mk(16'h0002, '0, '0, F_ZLO));
      exp_q.push_back(z);
      run_queue("ir_late", 0, 1, 5);

      // div with alu_done never set: 40 cycles in T4, illegal pulse, no HI/LO
      ir = 32'h78900000;
      alu_done = 1'b0;
      push_fetch(0);
      exp_q.push_back(mk('0, 16'h0002, '0, F_Y_IN));
      for (int k = 0; k < 40; k++) exp_q.push_back(mk('0, 16'h0004, 5'h0F, F_Z_IN));
      exp_q.push_back(mk('0, '0, '0, F_ILL));
      exp_q.push_back(z);
      run_queue("div_to", 0, 1, -1);

      // clr pulse in T4 of and
      ir = 32'h28918000;
      push_fetch(0);
      exp_q.push_back(mk('0, 16'h0004, '0, F_Y_IN));
      exp_q.push_back(mk('0, 16'h0008, 5'h05, F_Z_IN));
      run_queue("pre_clr", 0, 1, -1);
      clr = 1'b0;
      #1 check("clr_mid", z);
      #1 clr = 1'b1;
      ir = 32'hD0000000;
      push_fetch(0);
      exp_q.push_back(z);
      exp_q.push_back(z);
      run_queue("post_clr", 0, 1, -1);

      // halt: stays halted with run high until clr
      ir = 32'hD8000000;
      push_fetch(0);
      exp_q.push_back(z);
      for (int k = 0; k < 5; k++) exp_q.push_back(mk('0, '0, '0, F_HALT));
      run_queue("halt", 0, 1000, -1);
      clr = 1'b0;
      #1 check("halt_clr", z);
      clr = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
